// File: rtl/scalar_product_feeder.sv
// scalar_product_feeder
// Upstream stage of scalar_product. It collects (a, b) element pairs, one per
// cycle, into packed A/B vectors. Each finished vector pair is presented with
// valid/ready and held stable until it is taken. A last marker ends a short
// vector early, and the unused upper lanes read as zero.
//
// Optional feature: define SP_FEEDER_PINGPONG_EN to get two vector banks.
// With two banks, one bank fills while the other is presented, which sustains
// one element per cycle. With the macro undefined, a single bank alternates
// between filling and presenting.
module scalar_product_feeder #(
    parameter int Nbits = 4,
    parameter int Ndata = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Nbits-1:0]       in_a,
    input  logic [Nbits-1:0]       in_b,
    input  logic                   in_last,
    output logic                   vec_valid,
    input  logic                   vec_ready,
    output logic [Ndata*Nbits-1:0] out_A,
    output logic [Ndata*Nbits-1:0] out_B,
    output logic [$clog2(Ndata):0] fill_level
);

    localparam int CW = $clog2(Ndata) + 1;
    localparam int IW = $clog2(Ndata);
    localparam logic [CW-1:0] LastLane = CW'(Ndata - 1);

    typedef logic [Ndata-1:0][Nbits-1:0] vec_t;

    // count_q is the number of elements written into the filling buffer, so
    // while a buffer is filling it is also the lane index of the next element.
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] lane;

    assign lane = count_q[IW-1:0];

`ifdef SP_FEEDER_PINGPONG_EN

    // Each bank has a "done" flag that marks a completed vector still waiting
    // for the consumer. wrPtr selects the bank being filled and rdPtr selects
    // the bank being presented. Both pointers advance alternately, so vectors
    // are presented in the order they completed.
    logic       wrPtr_q, wrPtr_d;
    logic       rdPtr_q, rdPtr_d;
    logic [1:0] done_q, done_d;
    vec_t       bankA_q [2];
    vec_t       bankA_d [2];
    vec_t       bankB_q [2];
    vec_t       bankB_d [2];
    logic       inReadyInt;
    logic       vecValidInt;

    assign inReadyInt  = ~done_q[wrPtr_q];
    assign vecValidInt = done_q[rdPtr_q];

    // Bank storage, completion flags, bank pointers and the fill counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= 1'b0;
            rdPtr_q    <= 1'b0;
            done_q     <= 2'b00;
            count_q    <= '0;
            bankA_q[0] <= '0;
            bankA_q[1] <= '0;
            bankB_q[0] <= '0;
            bankB_q[1] <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            done_q  <= done_d;
            count_q <= count_d;
            bankA_q <= bankA_d;
            bankB_q <= bankB_d;
        end
    end

    // The presented bank is released and cleared when it is taken. The filling
    // bank is a different bank whenever an element can be written, so a take
    // and a write in the same cycle never touch the same bank.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        done_d  = done_q;
        count_d = count_q;
        bankA_d = bankA_q;
        bankB_d = bankB_q;

        if (vecValidInt && vec_ready) begin
            bankA_d[rdPtr_q] = '0;
            bankB_d[rdPtr_q] = '0;
            done_d[rdPtr_q]  = 1'b0;
            rdPtr_d          = ~rdPtr_q;
        end

        if (in_valid && inReadyInt) begin
            bankA_d[wrPtr_q][lane] = in_a;
            bankB_d[wrPtr_q][lane] = in_b;
            if (count_q == LastLane || in_last) begin
                done_d[wrPtr_q] = 1'b1;
                wrPtr_d         = ~wrPtr_q;
                count_d         = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Outputs: present the bank pointed to by rdPtr and report the filling bank
    always_comb begin
        in_ready   = inReadyInt;
        vec_valid  = vecValidInt;
        out_A      = bankA_q[rdPtr_q];
        out_B      = bankB_q[rdPtr_q];
        fill_level = count_q;
    end

`else

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e state_q, state_d;
    vec_t   bufA_q, bufA_d;
    vec_t   bufB_q, bufB_d;

    // State register, element counter and the single pair of vector buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
            bufA_q  <= '0;
            bufB_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bufA_q  <= bufA_d;
            bufB_q  <= bufB_d;
        end
    end

    // FILL writes lanes until the last lane or a marked element, then FULL
    // holds everything until the consumer takes it. At that point the buffers
    // are cleared, so the next short vector is padded with zeros.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bufA_d  = bufA_q;
        bufB_d  = bufB_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    bufA_d[lane] = in_a;
                    bufB_d[lane] = in_b;
                    count_d      = count_q + CW'(1);
                    if (count_q == LastLane || in_last) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (vec_ready) begin
                    bufA_d  = '0;
                    bufB_d  = '0;
                    count_d = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Outputs: handshakes follow the state, and the data comes straight from the buffers
    always_comb begin
        in_ready   = (state_q == FILL);
        vec_valid  = (state_q == FULL);
        out_A      = bufA_q;
        out_B      = bufB_q;
        fill_level = count_q;
    end

`endif

endmodule

// File: tb/tb_scalar_product_feeder.sv
// tb_scalar_product_feeder
// Self-checking bench for scalar_product_feeder. The behavioural model keeps
// completed vectors in a queue, and a compare process checks the DUT against
// that queue on every cycle. Define SP_FEEDER_PINGPONG_EN to check the two-bank build.
`timescale 1ns/1ps
module tb_scalar_product_feeder;

   localparam int NBITS = 4;
   localparam int NDATA = 4;
   localparam int VW    = NBITS * NDATA;
`ifdef SP_FEEDER_PINGPONG_EN
   localparam int CAP      = 2;
   localparam bit PINGPONG = 1'b1;
`else
   localparam int CAP      = 1;
   localparam bit PINGPONG = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             inValid;
   logic             inReady;
   logic [NBITS-1:0] inA;
   logic [NBITS-1:0] inB;
   logic             inLast;
   logic             vecValid;
   logic             vecReady;
   logic [VW-1:0]    outA;
   logic [VW-1:0]    outB;
   logic [2:0]       fillLevel;

   int testsRun    = 0;
   int testsFailed = 0;
   bit checkEn     = 1'b0;
   int readyLow;
   int pulses;
   int lastPulse;

   typedef struct {
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      int            len;
   } vecRec_t;

   vecRec_t       modelQ[$];
   logic [VW-1:0] curA;
   logic [VW-1:0] curB;
   int            curLen;

   scalar_product_feeder #(.Nbits(NBITS), .Ndata(NDATA)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_a       (inA),
      .in_b       (inB),
      .in_last    (inLast),
      .vec_valid  (vecValid),
      .vec_ready  (vecReady),
      .out_A      (outA),
      .out_B      (outB),
      .fill_level (fillLevel)
   );

   always #5 clk = ~clk;

   // Compare one value against its expectation and record the result
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one element and hold it until the feeder takes it; call just after a rising edge
   task automatic applyStimulus(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b, input logic last);
      int guard = 0;
      inValid = 1'b1;
      inA     = a;
      inB     = b;
      inLast  = last;
      @(negedge clk);
      while (!inReady && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) checkOutput("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   // Model: a partial vector being collected plus a queue of completed vectors waiting to be taken
   always @(posedge clk or negedge rst_n) begin : modelUpdate
      logic          canAccept;
      logic [VW-1:0] nA;
      logic [VW-1:0] nB;
      vecRec_t       rec;
      if (!rst_n) begin
         modelQ.delete();
         curA   <= '0;
         curB   <= '0;
         curLen <= 0;
      end else begin
         canAccept = (modelQ.size() < CAP);
         if (modelQ.size() != 0 && vecReady) void'(modelQ.pop_front());
         if (inValid && canAccept) begin
            nA = curA;
            nB = curB;
            nA[curLen*NBITS +: NBITS] = inA;
            nB[curLen*NBITS +: NBITS] = inB;
            if (curLen == NDATA - 1 || inLast) begin
               rec.a   = nA;
               rec.b   = nB;
               rec.len = curLen + 1;
               modelQ.push_back(rec);
               curA   <= '0;
               curB   <= '0;
               curLen <= 0;
            end else begin
               curA   <= nA;
               curB   <= nB;
               curLen <= curLen + 1;
            end
         end
      end
   end

   // Check the DUT against the model on every falling edge outside reset
   always @(negedge clk) begin
      if (rst_n && checkEn) begin
         checkOutput("vec_valid", {31'd0, vecValid}, {31'd0, modelQ.size() != 0});
         checkOutput("in_ready", {31'd0, inReady}, {31'd0, modelQ.size() < CAP});
         if (modelQ.size() != 0) begin
            checkOutput("out_A", outA, modelQ[0].a);
            checkOutput("out_B", outB, modelQ[0].b);
            if (!PINGPONG) checkOutput("fill_level_held", {29'd0, fillLevel}, modelQ[0].len);
            else           checkOutput("fill_level", {29'd0, fillLevel}, curLen);
         end else begin
            checkOutput("fill_level", {29'd0, fillLevel}, curLen);
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      inValid  = 1'b0;
      inA      = '0;
      inB      = '0;
      inLast   = 1'b0;
      vecReady = 1'b0;
      #3;
      checkOutput("reset_vec_valid", {31'd0, vecValid}, 32'd0);
      checkOutput("reset_in_ready", {31'd0, inReady}, 32'd1);
      checkOutput("reset_out_A", outA, 32'd0);
      checkOutput("reset_fill_level", {29'd0, fillLevel}, 32'd0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      checkEn = 1'b1;
      @(posedge clk);
      #1;

      // Full vector with the last marker on the final element
      vecReady = 1'b1;
      applyStimulus(4'd1, 4'd6, 1'b0);
      applyStimulus(4'd2, 4'd5, 1'b0);
      applyStimulus(4'd3, 4'd4, 1'b0);
      applyStimulus(4'd2, 4'd1, 1'b1);
      checkOutput("full_vec_valid", {31'd0, vecValid}, 32'd1);
      checkOutput("full_out_A", outA, 32'h2321);
      checkOutput("full_out_B", outB, 32'h1456);
`ifndef SP_FEEDER_PINGPONG_EN
      checkOutput("full_fill_level", {29'd0, fillLevel}, 32'd4);
`endif
      @(posedge clk);
      #1;
      checkOutput("full_after_vec_valid", {31'd0, vecValid}, 32'd0);
      checkOutput("full_after_in_ready", {31'd0, inReady}, 32'd1);

      // Short vector padded with zeros
      applyStimulus(4'd15, 4'd15, 1'b0);
      applyStimulus(4'd15, 4'd15, 1'b1);
      checkOutput("short_vec_valid", {31'd0, vecValid}, 32'd1);
      checkOutput("short_out_A", outA, 32'h00FF);
      checkOutput("short_out_B", outB, 32'h00FF);
`ifndef SP_FEEDER_PINGPONG_EN
      checkOutput("short_fill_level", {29'd0, fillLevel}, 32'd2);
`endif
      @(posedge clk);
      #1;

      // Backpressure: the completed vector is held for five cycles
      vecReady = 1'b0;
      applyStimulus(4'd1, 4'd1, 1'b0);
      applyStimulus(4'd15, 4'd15, 1'b0);
      applyStimulus(4'd15, 4'd15, 1'b0);
      applyStimulus(4'd15, 4'd15, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_vec_valid", {31'd0, vecValid}, 32'd1);
         checkOutput("bp_out_A", outA, 32'hFFF1);
         checkOutput("bp_out_B", outB, 32'hFFF1);
`ifndef SP_FEEDER_PINGPONG_EN
         checkOutput("bp_in_ready", {31'd0, inReady}, 32'd0);
`endif
         @(posedge clk);
         #1;
      end
      vecReady = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_released", {31'd0, vecValid}, 32'd0);

      // Reset in the middle of a fill discards the partial vector
      applyStimulus(4'd7, 4'd7, 1'b0);
      applyStimulus(4'd8, 4'd8, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_vec_valid", {31'd0, vecValid}, 32'd0);
      checkOutput("rst_fill_level", {29'd0, fillLevel}, 32'd0);
      checkOutput("rst_out_A", outA, 32'd0);
      #1;
      rst_n = 1'b1;
      applyStimulus(4'd1, 4'd6, 1'b0);
      applyStimulus(4'd2, 4'd5, 1'b0);
      applyStimulus(4'd3, 4'd4, 1'b0);
      applyStimulus(4'd2, 4'd1, 1'b0);
      checkOutput("rst_next_out_A", outA, 32'h2321);
      checkOutput("rst_next_out_B", outB, 32'h1456);
      @(posedge clk);
      #1;

      // Idle gaps of three cycles between the elements
      applyStimulus(4'd1, 4'd6, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      applyStimulus(4'd2, 4'd5, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("gap_fill_level", {29'd0, fillLevel}, 32'd2);
      applyStimulus(4'd3, 4'd4, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      applyStimulus(4'd2, 4'd1, 1'b1);
      checkOutput("gap_out_A", outA, 32'h2321);
      checkOutput("gap_out_B", outB, 32'h1456);
      @(posedge clk);
      #1;

`ifdef SP_FEEDER_PINGPONG_EN
      // Three full vectors back to back: the input is never stalled and a vector appears every four cycles
      readyLow  = 0;
      pulses    = 0;
      lastPulse = -1;
      for (int c = 0; c < 15; c++) begin
         inValid = (c < 12);
         inA     = NBITS'(c + 1);
         inB     = NBITS'(15 - c);
         inLast  = 1'b0;
         @(negedge clk);
         if (inValid && !inReady) readyLow++;
         if (vecValid) begin
            if (lastPulse >= 0) checkOutput("pp_pulse_spacing", c - lastPulse, 32'd4);
            lastPulse = c;
            pulses++;
         end
         @(posedge clk);
         #1;
      end
      inValid = 1'b0;
      checkOutput("pp_in_ready_low", readyLow, 32'd0);
      checkOutput("pp_pulses", pulses, 32'd3);
`endif

      // Random traffic with random gaps, last markers and backpressure
      for (int c = 0; c < 1500; c++) begin
         inValid  = ($urandom_range(0, 3) != 0);
         inA      = NBITS'($urandom);
         inB      = NBITS'($urandom);
         inLast   = ($urandom_range(0, 4) == 0);
         vecReady = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      inValid  = 1'b0;
      inLast   = 1'b0;
      vecReady = 1'b1;
      repeat (5) begin @(posedge clk); #1; end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/scalar_product_feeder.md
Name: scalar_product_feeder

Overview:
Upstream stage of scalar_product. Accepts (a, b) operand pairs one element per cycle over a valid/ready stream and assembles them into the packed A/B vectors that scalar_product consumes. Presents each completed vector pair with valid/ready, holding it stable until it is accepted. Short vectors are supported through a last marker and are zero-padded.

Parameters:
Nbits, 4, width of one element.
Ndata, 4, elements per vector; legal values are Ndata >= 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  an element pair is present on in_a/in_b.
in_ready  output  1  feeder can accept an element this cycle.
in_a  input  Nbits  element of vector A.
in_b  input  Nbits  element of vector B.
in_last  input  1  marks the final element of the current vector; qualified by in_valid.
vec_valid  output  1  out_A/out_B hold a complete vector pair.
vec_ready  input  1  downstream accepts the vector pair.
out_A  output  Ndata*Nbits  packed vector A; element i is at bits [i*Nbits +: Nbits].
out_B  output  Ndata*Nbits  packed vector B; same packing as out_A.
fill_level  output  clog2(Ndata)+1  number of elements written into the filling buffer.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on rst_n. Any rst_n low clears state to FILL, buffers to 0, and count to 0. Outputs during and after reset: vec_valid=0, in_ready=1, out_A=0, out_B=0, fill_level=0. A partially filled vector is discarded.
- Element accept: occurs on a rising edge with in_valid && in_ready. The element is written to lane index = count, then count increments. The first accepted element goes to the lowest lane.
- State machine has two states, FILL and FULL.
  - FILL: in_ready=1, vec_valid=0.
  - FILL -> FULL when the accepted element has count==Ndata-1 or in_last=1. Lanes above the last written lane read as 0. vec_valid rises on the cycle after the final accept, so latency from the final element to vec_valid is 1 cycle.
  - in_last on lane Ndata-1 is equivalent to no in_last.
  - An input with in_last=1 but in_valid=0 is ignored.
  - FULL: in_ready=0, vec_valid=1. out_A, out_B and fill_level are held stable until vec_ready=1.
  - FULL -> FILL on vec_valid && vec_ready. On that transition, buffers clear to 0 and count clears to 0. in_ready returns to 1 the following cycle.
- Throughput without the optional feature is one vector per Ndata+1 cycles at best.
- Data is pass-through only: no arithmetic, no width change. Elements are unsigned, Nbits wide.
- vec_valid, once high, never drops without vec_ready; the only exception is reset.
- in_valid=0 in FILL holds the state and count; gaps of any length are allowed.
- The A/B product is computed downstream, combinationally, from out_A/out_B.

Optional Feature:
Macro SP_FEEDER_PINGPONG_EN.
- Defined:
  - Two vector banks. One fills while the other is presented.
  - in_ready=0 only when both banks are complete.
  - When the presented bank is accepted and the other bank is complete, the other bank is presented on the same edge (vec_valid stays 1).
  - Filling may continue in the cycle a vector is accepted.
  - Sustained throughput is 1 element/cycle. Completion order equals presentation order.
  - fill_level reports the filling bank.
- Undefined: single-bank behaviour exactly as in Behaviour.

Test Plan:
- Full vector: stream (a,b) = (1,6),(2,5),(3,4),(2,1) with in_last on the 4th element; vec_ready=1. Required: vec_valid 1 cycle after the 4th accept, out_A=16'h2321, out_B=16'h1456, fill_level=4. Then vec_valid=0 and in_ready=1 on the next cycle.
- Short vector: stream (15,15),(15,15) with in_last on the 2nd element. Required: out_A=16'h00FF, out_B=16'h00FF, fill_level=2.
- Backpressure: complete the vector (1,1),(15,15),(15,15),(15,15), then hold vec_ready=0 for 5 cycles. Required: out_A=out_B=16'hFFF1 stable, vec_valid=1, and in_ready=0 (base build) for all 5 cycles; accept on the 6th cycle.
- Reset mid-fill: accept 2 elements, pulse rst_n low between clock edges. Required: immediately vec_valid=0, fill_level=0, out_A=0. A following 4-element vector is assembled with no residue.
- Idle gaps: insert 3 in_valid=0 cycles between each element of the first vector. Required: same out_A/out_B as in the first test; fill_level increments only on accepts.
- SP_FEEDER_PINGPONG_EN: stream 3 full vectors back-to-back with vec_ready=1. Required: in_ready is never 0, vec_valid pulses every 4 cycles, and the vectors appear in order.
